// File: rtl/clic_elastic_pipeline_pkg.sv
// rtl/clic_elastic_pipeline_pkg.sv - shared types for the CLIC elastic pipeline
package clic_elastic_pipeline_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        PRIV_U = 2'd0,
        PRIV_S = 2'd1,
        PRIV_M = 2'd3
    } mode_t;

    typedef enum logic [11:0] {
        CSR_INVALID = 12'h000,
        CSR_MSTATUS = 12'h300,
        CSR_MTVEC   = 12'h305,
        CSR_MEPC    = 12'h341
    } csr_reg_t;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_CSRW = 3'd1,
        OP_MRET = 3'd2,
        OP_SRET = 3'd3,
        OP_WFI  = 3'd4
    } op_e;

    typedef struct packed {
        logic       pending;
        logic [7:0] id;
    } irq_t;

    typedef struct packed {
        op_e             op;
        csr_reg_t        csr_addr;
        logic [XLEN-1:0] wdata;
    } inst_t;

    typedef struct packed {
        logic            valid;
        mode_t           priv_lvl;
        logic [XLEN-1:0] pc;
        irq_t            ex;
        inst_t           inst;
    } clic_pipe_stage_t;

endpackage

// File: rtl/clic_elastic_pipeline_if.sv
// rtl/clic_elastic_pipeline_if.sv - fetch handshake channel into the pipeline
interface clic_elastic_pipeline_if;
    import clic_elastic_pipeline_pkg::*;

    logic [XLEN-1:0] pc;
    logic            fetch_valid;
    logic            fetch_ready;
    irq_t            irq;
    mode_t           priv_lvl;

    modport master (output pc, fetch_valid, irq, priv_lvl, input fetch_ready);
    modport slave  (input pc, fetch_valid, irq, priv_lvl, output fetch_ready);
endinterface

// File: rtl/clic_elastic_pipeline_rom.sv
// rtl/clic_elastic_pipeline_rom.sv - combinational instruction ROM indexed by fetch PC
module clic_elastic_pipeline_rom
    import clic_elastic_pipeline_pkg::*;
(
    input  logic [XLEN-1:0] addr,
    output inst_t           inst
);

    // Unlisted addresses decode to a NOP; 0x400 holds an undefined opcode.
    always_comb begin
        inst = '0;
        case (addr)
            32'h0000_0100: inst = '{op: OP_CSRW, csr_addr: CSR_MTVEC, wdata: 32'h8000_0000};
            32'h0000_0104: inst = '{op: OP_CSRW, csr_addr: CSR_MEPC,  wdata: 32'h0000_1234};
            32'h0000_0200: inst.op = OP_MRET;
            32'h0000_0204: inst.op = OP_SRET;
            32'h0000_0300: inst.op = OP_WFI;
            32'h0000_0400: inst.op = op_e'(3'd7);
            default:       inst = '0;
        endcase
    end

endmodule

// File: rtl/clic_elastic_pipeline.sv
// rtl/clic_elastic_pipeline.sv - N-stage elastic retire pipeline; WFI parking under CLIC_PIPE_WFI_EN
module clic_elastic_pipeline
    import clic_elastic_pipeline_pkg::*;
#(
    parameter  int N_STAGES = 3,
    parameter  int CNT_W    = 32,
    localparam int OCC_W    = $clog2(N_STAGES + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    clic_elastic_pipeline_if.slave fetch,
    input  logic                   flush_i,
    input  logic                   stall_i,
    input  logic                   wfi_wake_i,
    output logic                   csr_write_o,
    output csr_reg_t               csr_addr_o,
    output logic [XLEN-1:0]        csr_wdata_o,
    output logic                   mret_o,
    output logic                   sret_o,
    output logic                   inst_valid_o,
    output mode_t                  inst_priv_lvl_o,
    output logic [XLEN-1:0]        inst_pc_o,
    output irq_t                   irq_o,
    output logic [CNT_W-1:0]       retire_cnt_o,
    output logic [OCC_W-1:0]       occupancy_o
);

    clic_pipe_stage_t    s_q [N_STAGES];
    clic_pipe_stage_t    s_d [N_STAGES];
    clic_pipe_stage_t    tail;
    logic [N_STAGES-1:0] adv;
    inst_t               rom_inst;
    logic                fetch_ready;
    logic                fetch_fire;
    logic                retire_en;
    logic                wfi_hold;
    logic [CNT_W-1:0]    cnt_q;
    logic [OCC_W-1:0]    occ_q;
    logic [OCC_W-1:0]    occ_d;

    assign tail = s_q[N_STAGES-1];

    clic_elastic_pipeline_rom u_rom (
        .addr (fetch.pc),
        .inst (rom_inst)
    );

`ifdef CLIC_PIPE_WFI_EN
    assign wfi_hold = tail.valid & (tail.inst.op == OP_WFI) & ~wfi_wake_i;
`else
    logic wfi_wake_unused;
    assign wfi_wake_unused = wfi_wake_i;
    assign wfi_hold        = 1'b0;
`endif

    assign retire_en = tail.valid & ~stall_i & ~flush_i & ~wfi_hold;

    // A stage may advance if it is empty or everything ahead of it advances.
    always_comb begin
        logic a;
        adv = '0;
        a   = ~tail.valid | retire_en;
        adv[N_STAGES-1] = a;
        for (int i = N_STAGES - 2; i >= 0; i--) begin
            a      = ~s_q[i].valid | a;
            adv[i] = a;
        end
    end

    // Gating with rst_ni keeps the handshake closed while reset is held.
    assign fetch_ready       = adv[0] & ~flush_i & rst_ni;
    assign fetch.fetch_ready = fetch_ready;
    assign fetch_fire        = fetch.fetch_valid & fetch_ready;

    always_comb begin
        for (int i = 0; i < N_STAGES; i++) s_d[i] = s_q[i];
        if (flush_i) begin
            for (int i = 0; i < N_STAGES; i++) s_d[i] = '0;
        end else begin
            for (int i = N_STAGES - 1; i > 0; i--) begin
                if (adv[i]) s_d[i] = s_q[i-1];
            end
            if (adv[0]) begin
                s_d[0] = '0;
                if (fetch_fire) begin
                    s_d[0].valid    = 1'b1;
                    s_d[0].priv_lvl = fetch.priv_lvl;
                    s_d[0].pc       = fetch.pc;
                    s_d[0].ex       = fetch.irq;
                    s_d[0].inst     = rom_inst;
                end
            end
        end
    end

    always_comb begin
        occ_d = '0;
        for (int i = 0; i < N_STAGES; i++) occ_d = occ_d + OCC_W'(s_d[i].valid);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_STAGES; i++) s_q[i] <= '0;
            cnt_q <= '0;
            occ_q <= '0;
        end else begin
            for (int i = 0; i < N_STAGES; i++) s_q[i] <= s_d[i];
            occ_q <= occ_d;
            if (retire_en) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Side effects fire only on the retiring cycle, never while parked or stalled.
    always_comb begin
        csr_write_o = 1'b0;
        csr_addr_o  = CSR_INVALID;
        csr_wdata_o = '0;
        mret_o      = 1'b0;
        sret_o      = 1'b0;
        if (retire_en) begin
            case (tail.inst.op)
                OP_CSRW: begin
                    csr_write_o = 1'b1;
                    csr_addr_o  = tail.inst.csr_addr;
                    csr_wdata_o = tail.inst.wdata;
                end
                OP_MRET: mret_o = 1'b1;
                OP_SRET: sret_o = 1'b1;
                default: csr_write_o = 1'b0;
            endcase
        end
    end

    assign inst_valid_o    = tail.valid;
    assign inst_priv_lvl_o = tail.valid ? tail.priv_lvl : PRIV_U;
    assign inst_pc_o       = tail.valid ? tail.pc : '0;
    assign irq_o           = tail.valid ? tail.ex : '0;
    assign retire_cnt_o    = cnt_q;
    assign occupancy_o     = occ_q;

endmodule
